alu_exec_unit: RTL and testbench



---
 rtl/alu_exec_pkg.sv | 23 ++
 rtl/mul8_iter.sv | 70 +++++++
 rtl/alu_exec_unit.sv | 171 +++++++++++++++++
 tb/tb_alu_exec_unit.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_exec_pkg.sv
// rtl/alu_exec_pkg.sv - opcodes, FSM state encoding and default widths for the execute stage
package alu_exec_pkg;

  localparam int DW_DEFAULT = 8;
  localparam int AW_DEFAULT = 3;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_MUL = 3'd6;
  localparam logic [2:0] OP_LDI = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2,
    ST_WB   = 2'd3
  } state_e;

endpackage

// File: rtl/mul8_iter.sv
// rtl/mul8_iter.sv - iterative shift-add multiplier, one multiplier bit per cycle, LSB first
module mul8_iter
  import alu_exec_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [DW-1:0]   a,
  input  logic [DW-1:0]   b,
  output logic            done,
  output logic [2*DW-1:0] product
);

  localparam int CW = $clog2(DW);
  localparam logic [CW-1:0] LAST = CW'(DW - 1);

  logic [2*DW-1:0] acc_q, acc_d;
  logic [2*DW-1:0] mcand_q, mcand_d;
  logic [DW-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            run_q, run_d;

  // done is high during the final iteration; the product is complete after that edge
  assign done    = run_q && (cnt_q == LAST);
  assign product = acc_q;

  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    run_d    = run_q;
    if (start) begin
      acc_d    = '0;
      mcand_d  = {{DW{1'b0}}, a};
      mplier_d = b;
      cnt_d    = '0;
      run_d    = 1'b1;
    end else if (run_q) begin
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CW'(1);
      if (done) begin
        run_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      run_q    <= run_d;
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - multi-cycle execute/writeback stage feeding the 8x8 register file
module alu_exec_unit
  import alu_exec_pkg::*;
#(
  parameter int DW = DW_DEFAULT,
  parameter int AW = AW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    in_op,
  input  logic [AW-1:0] in_rd,
  input  logic [AW-1:0] in_rs1,
  input  logic [AW-1:0] in_rs2,
  input  logic [DW-1:0] in_imm,
  output logic [AW-1:0] reg1_read_addr,
  output logic [AW-1:0] reg2_read_addr,
  input  logic [DW-1:0] reg1_read_data,
  input  logic [DW-1:0] reg2_read_data,
  output logic          reg_write_en,
  output logic [AW-1:0] reg_write_addr,
  output logic [DW-1:0] reg_write_data,
  output logic          flag_z,
  output logic          flag_c,
  output logic          busy
);

  state_e          state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic [AW-1:0]   rd_q, rd_d;
  logic [AW-1:0]   rs1_q, rs1_d;
  logic [AW-1:0]   rs2_q, rs2_d;
  logic [DW-1:0]   imm_q, imm_d;
  logic [DW-1:0]   result_q, result_d;
  logic            carry_q, carry_d;
  logic            flag_z_q, flag_z_d;
  logic            flag_c_q, flag_c_d;

  logic            mul_start;
  logic            mul_done;
  logic [2*DW-1:0] mul_product;

  logic [DW-1:0]   alu_res;
  logic            alu_carry;
  logic [DW:0]     sum_w;
  logic [DW:0]     diff_w;
  logic [2*DW-1:0] shl_w;
  logic [DW-1:0]   wb_data;
  logic            wb_carry;

  mul8_iter #(.DW(DW)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (reg1_read_data),
    .b       (reg2_read_data),
    .done    (mul_done),
    .product (mul_product)
  );

  // Bit DW of the widened sum/difference/shift is the carry, borrow or last bit shifted out
  assign sum_w  = {1'b0, reg1_read_data} + {1'b0, reg2_read_data};
  assign diff_w = {1'b0, reg1_read_data} - {1'b0, reg2_read_data};
  assign shl_w  = {{DW{1'b0}}, reg1_read_data} << reg2_read_data[2:0];

  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    case (op_q)
      OP_ADD: begin alu_res = sum_w[DW-1:0];  alu_carry = sum_w[DW];  end
      OP_SUB: begin alu_res = diff_w[DW-1:0]; alu_carry = diff_w[DW]; end
      OP_AND: alu_res = reg1_read_data & reg2_read_data;
      OP_OR:  alu_res = reg1_read_data | reg2_read_data;
      OP_XOR: alu_res = reg1_read_data ^ reg2_read_data;
      OP_SHL: begin alu_res = shl_w[DW-1:0];  alu_carry = shl_w[DW];  end
      OP_LDI: alu_res = imm_q;
      default: alu_res = '0;
    endcase
  end

  assign wb_data  = (op_q == OP_MUL) ? mul_product[DW-1:0] : result_q;
  assign wb_carry = (op_q == OP_MUL) ? (|mul_product[2*DW-1:DW]) : carry_q;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    rd_d      = rd_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    imm_d     = imm_q;
    result_d  = result_q;
    carry_d   = carry_q;
    flag_z_d  = flag_z_q;
    flag_c_d  = flag_c_q;
    mul_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          op_d    = in_op;
          rd_d    = in_rd;
          rs1_d   = in_rs1;
          rs2_d   = in_rs2;
          imm_d   = in_imm;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (op_q == OP_MUL) begin
          mul_start = 1'b1;
          state_d   = ST_MUL;
        end else begin
          result_d = alu_res;
          carry_d  = alu_carry;
          state_d  = ST_WB;
        end
      end
      ST_MUL: begin
        if (mul_done) begin
          state_d = ST_WB;
        end
      end
      ST_WB: begin
        if (op_q != OP_LDI) begin
          flag_z_d = (wb_data == '0);
          flag_c_d = wb_carry;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_ADD;
      rd_q     <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      imm_q    <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      flag_z_q <= 1'b0;
      flag_c_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      imm_q    <= imm_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      flag_z_q <= flag_z_d;
      flag_c_q <= flag_c_d;
    end
  end

  // Strobe decodes straight from state so an asynchronous reset removes it at once
  assign in_ready       = (state_q == ST_IDLE);
  assign busy           = (state_q != ST_IDLE);
  assign reg_write_en   = (state_q == ST_WB);
  assign reg_write_addr = rd_q;
  assign reg_write_data = wb_data;
  assign reg1_read_addr = rs1_q;
  assign reg2_read_addr = rs2_q;
  assign flag_z         = flag_z_q;
  assign flag_c         = flag_c_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - self-checking bench for alu_exec_unit driving a register file model
`timescale 1ns/1ps
module tb_alu_exec_unit;
  import alu_exec_pkg::*;

  localparam int DW = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    in_op = 3'd0;
  logic [AW-1:0] in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [DW-1:0] in_imm = '0;
  logic [AW-1:0] reg1_read_addr, reg2_read_addr;
  logic [DW-1:0] reg1_read_data, reg2_read_data;
  logic          reg_write_en;
  logic [AW-1:0] reg_write_addr;
  logic [DW-1:0] reg_write_data;
  logic          flag_z, flag_c, busy;

  always #5 clk = ~clk;

  alu_exec_unit #(.DW(DW), .AW(AW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_op          (in_op),
    .in_rd          (in_rd),
    .in_rs1         (in_rs1),
    .in_rs2         (in_rs2),
    .in_imm         (in_imm),
    .reg1_read_addr (reg1_read_addr),
    .reg2_read_addr (reg2_read_addr),
    .reg1_read_data (reg1_read_data),
    .reg2_read_data (reg2_read_data),
    .reg_write_en   (reg_write_en),
    .reg_write_addr (reg_write_addr),
    .reg_write_data (reg_write_data),
    .flag_z         (flag_z),
    .flag_c         (flag_c),
    .busy           (busy)
  );

  // Downstream 8x8 register file: combinational read, write on the rising edge
  logic [DW-1:0] rf [8] = '{default: '0};
  always @(posedge clk) if (reg_write_en) rf[reg_write_addr] <= reg_write_data;
  assign reg1_read_data = rf[reg1_read_addr];
  assign reg2_read_data = rf[reg2_read_addr];

  typedef struct { int cyc; int addr; int data; bit upd; bit z; bit c; } wb_t;
  wb_t exp_q[$];
  int  model_rf [8] = '{default: 0};
  bit  m_z = 0, m_c = 0;
  int  ready_at = 0;
  int  cyc = 0;
  int  passed = 0, total = 0;
  int  strobes = 0, last_acc = 0, last_wb = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready", int'(in_ready), int'(cyc >= ready_at));
      chk("busy", int'(busy), int'(cyc < ready_at));
      chk("flag_z", int'(flag_z), int'(m_z));
      chk("flag_c", int'(flag_c), int'(m_c));
      if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        chk("wb_missed_cycle", cyc, exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
      if (reg_write_en) begin
        strobes++;
        last_wb = cyc;
        if (exp_q.size() == 0) chk("wb_unexpected_strobe", int'(reg_write_en), 0);
        else begin
          chk("wb_cycle", cyc, exp_q[0].cyc);
          chk("wb_addr", int'(reg_write_addr), exp_q[0].addr);
          chk("wb_data", int'(reg_write_data), exp_q[0].data);
          model_rf[exp_q[0].addr] = exp_q[0].data;
          if (exp_q[0].upd) begin m_z = exp_q[0].z; m_c = exp_q[0].c; end
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic issue(input logic [2:0] op, input int rd, input int rs1, input int rs2, input int imm);
    int a, b, res, sh, lat, n;
    bit c;
    @(negedge clk);
    in_valid = 1'b1; in_op = op; in_rd = AW'(rd); in_rs1 = AW'(rs1); in_rs2 = AW'(rs2); in_imm = DW'(imm);
    n = 0;
    while (!in_ready && n < 40) begin @(negedge clk); n++; end
    if (!in_ready) begin chk("accept_timeout", int'(in_ready), 1); in_valid = 1'b0; return; end
    @(posedge clk); #1;
    last_acc = cyc;
    a = model_rf[rs1]; b = model_rf[rs2]; c = 0;
    case (op)
      OP_ADD: begin res = (a + b) % 256; c = (a + b) > 255; end
      OP_SUB: begin res = (a - b + 256) % 256; c = a < b; end
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_XOR: res = a ^ b;
      OP_SHL: begin sh = b % 8; res = (a * (1 << sh)) % 256; c = (sh != 0) && (((a >> (8 - sh)) & 1) == 1); end
      OP_MUL: begin res = (a * b) % 256; c = (a * b) > 255; end
      default: res = imm;
    endcase
    lat = (op == OP_MUL) ? 9 : 1;
    exp_q.push_back('{cyc + lat, rd, res, op != OP_LDI, res == 0, c});
    ready_at = cyc + lat + 1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    @(negedge clk); #1;
    in_valid = 1'b0;
    while ((exp_q.size() != 0 || !in_ready) && n < 40) begin @(negedge clk); #1; n++; end
    if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    exp_q.delete();
    m_z = 0; m_c = 0; ready_at = 0;
    in_valid = 1'b1; in_op = OP_LDI; in_rd = 3'd7; in_imm = 8'h5A;
    #1;
    chk("rst_write_en", int'(reg_write_en), 0);
    chk("rst_write_addr", int'(reg_write_addr), 0);
    chk("rst_write_data", int'(reg_write_data), 0);
    chk("rst_flags", int'({flag_z, flag_c}), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_read_addrs", int'({reg1_read_addr, reg2_read_addr}), 0);
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    int s0, r5_before;
    @(posedge clk); #2;
    reset_pulse();
    repeat (2) @(negedge clk);
    chk("no_accept_in_reset", int'(in_ready), 1);

    // ADD carry and zero
    issue(OP_LDI, 1, 0, 0, 8'h7F);
    issue(OP_LDI, 2, 0, 0, 8'h81);
    issue(OP_ADD, 3, 1, 2, 0);
    drain();
    chk("add_r3", int'(rf[3]), 8'h00);
    chk("add_zc", int'({flag_z, flag_c}), 2'b11);
    chk("add_wb_cycle", last_wb - last_acc + 1, 2);

    // SUB borrow
    issue(OP_LDI, 1, 0, 0, 8'h05);
    issue(OP_LDI, 2, 0, 0, 8'h07);
    issue(OP_SUB, 4, 1, 2, 0);
    drain();
    chk("sub_r4", int'(rf[4]), 8'hFE);
    chk("sub_zc", int'({flag_z, flag_c}), 2'b01);

    // Logic ops
    issue(OP_LDI, 1, 0, 0, 8'hF0);
    issue(OP_LDI, 2, 0, 0, 8'h3C);
    issue(OP_AND, 3, 1, 2, 0);
    issue(OP_OR,  4, 1, 2, 0);
    issue(OP_XOR, 6, 1, 2, 0);
    drain();
    chk("and_r3", int'(rf[3]), 8'h30);
    chk("or_r4", int'(rf[4]), 8'hFC);
    chk("xor_r6", int'(rf[6]), 8'hCC);

    // MUL
    issue(OP_LDI, 1, 0, 0, 8'h10);
    issue(OP_LDI, 2, 0, 0, 8'h11);
    issue(OP_MUL, 5, 1, 2, 0);
    drain();
    chk("mul_r5", int'(rf[5]), 8'h10);
    chk("mul_zc", int'({flag_z, flag_c}), 2'b01);
    chk("mul_wb_cycle", last_wb - last_acc + 1, 10);

    // SHL edges, plus rd == rs1
    issue(OP_LDI, 1, 0, 0, 8'h81);
    issue(OP_LDI, 2, 0, 0, 8'h01);
    issue(OP_SHL, 6, 1, 2, 0);
    drain();
    chk("shl1_r6", int'(rf[6]), 8'h02);
    chk("shl1_c", int'(flag_c), 1);
    issue(OP_LDI, 2, 0, 0, 8'h00);
    issue(OP_SHL, 7, 1, 2, 0);
    drain();
    chk("shl0_r7", int'(rf[7]), 8'h81);
    chk("shl0_zc", int'({flag_z, flag_c}), 2'b00);
    issue(OP_ADD, 1, 1, 1, 0);
    drain();
    chk("rd_eq_rs_r1", int'(rf[1]), 8'h02);

    // Back-to-back dependency with in_valid held high
    s0 = strobes;
    issue(OP_LDI, 1, 0, 0, 8'h03);
    issue(OP_ADD, 2, 1, 1, 0);
    drain();
    chk("b2b_r2", int'(rf[2]), 8'h06);
    chk("b2b_strobes", strobes - s0, 2);

    // Reset in cycle 5 of a MUL
    issue(OP_LDI, 1, 0, 0, 8'hFF);
    issue(OP_LDI, 2, 0, 0, 8'h01);
    issue(OP_ADD, 0, 1, 2, 0);
    issue(OP_LDI, 1, 0, 0, 8'h03);
    issue(OP_LDI, 2, 0, 0, 8'h05);
    drain();
    chk("pre_reset_zc", int'({flag_z, flag_c}), 2'b11);
    r5_before = int'(rf[5]);
    s0 = strobes;
    issue(OP_MUL, 5, 1, 2, 0);
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    reset_pulse();
    repeat (12) @(negedge clk);
    chk("rst_mul_strobes", strobes - s0, 0);
    chk("rst_mul_r5", int'(rf[5]), r5_before);
    chk("rst_mul_zc", int'({flag_z, flag_c}), 2'b00);
    chk("rst_mul_ready", int'(in_ready), 1);
    issue(OP_ADD, 6, 1, 2, 0);
    drain();
    chk("post_reset_r6", int'(rf[6]), 8'h08);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
